// File: rtl/tagged_fifo_pkg.sv
// Shared tag encodings and width helper for the tagged parallel FIFO.
// A tag's bit 1 marks start-of-row and bit 0 marks end-of-row.
package tagged_fifo_pkg;

  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_EOR    = 2'b01;
  localparam logic [1:0] TAG_SOR    = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  function automatic int unsigned word_width(input int unsigned data_width,
                                             input int unsigned tag_width);
    return data_width + tag_width;
  endfunction

endpackage

// File: rtl/tagged_fifo_mem.sv
// Multi-lane storage for the tagged FIFO: PAR_WRITE write lanes, PAR_READ asynchronous read lanes.
// Lane i addresses base + i, wrapping modulo DEPTH. Contents are not reset.
module tagged_fifo_mem #(
  parameter int unsigned WORD_WIDTH = 18,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 1,
  parameter int unsigned ADDR_LEN   = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [ADDR_LEN-1:0]              waddr,
  input  logic [PAR_WRITE*WORD_WIDTH-1:0]  wdata,
  input  logic [ADDR_LEN-1:0]              raddr,
  output logic [PAR_READ*WORD_WIDTH-1:0]   rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        mem[waddr + ADDR_LEN'(i)] <= wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      rdata[i*WORD_WIDTH +: WORD_WIDTH] = mem[raddr + ADDR_LEN'(i)];
    end
  end

endmodule

// File: rtl/tagged_par_fifo.sv
// Tagged FIFO with PAR_WRITE words per push and PAR_READ words per pop, counting complete rows
// and flagging malformed SOR/EOR tag sequences on the write side.
module tagged_par_fifo
  import tagged_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAG_WIDTH  = 2,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 1,
  parameter int unsigned ADDR_LEN   = $clog2(DEPTH)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic                                       wen,
  input  logic [PAR_WRITE*(DATA_WIDTH+TAG_WIDTH)-1:0] din,
  input  logic                                       ren,
  output logic [PAR_READ*(DATA_WIDTH+TAG_WIDTH)-1:0]  dout,
  output logic                                       dout_valid,
  output logic                                       full,
  output logic                                       empty,
  output logic [ADDR_LEN:0]                          count,
  output logic [ADDR_LEN:0]                          rows_avail,
  output logic                                       tag_err,
  output logic                                       overflow
);

  localparam int unsigned W = word_width(DATA_WIDTH, TAG_WIDTH);
  localparam logic [ADDR_LEN:0] DepthC = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN:0] PwC    = (ADDR_LEN+1)'(PAR_WRITE);
  localparam logic [ADDR_LEN:0] PrC    = (ADDR_LEN+1)'(PAR_READ);
  localparam logic [ADDR_LEN:0] OneC   = (ADDR_LEN+1)'(1);

  logic [ADDR_LEN-1:0]     wptr_q, rptr_q;
  logic [ADDR_LEN:0]       count_q, count_d, rows_q, rows_d;
  logic [ADDR_LEN:0]       push_rows, pop_rows;
  logic                    in_row_q, in_row_d, tag_err_q, tag_err_d, overflow_q;
  logic                    dout_valid_q;
  logic [PAR_READ*W-1:0]   dout_q, rdata;
  logic                    push, pop;
  logic [TAG_WIDTH-1:0]    lane_tag;
  logic [1:0]              tag;

  tagged_fifo_mem #(
    .WORD_WIDTH (W),
    .DEPTH      (DEPTH),
    .PAR_WRITE  (PAR_WRITE),
    .PAR_READ   (PAR_READ),
    .ADDR_LEN   (ADDR_LEN)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  // Occupancy decisions use start-of-cycle count, so a same-cycle pop never frees room for a push.
  always_comb begin
    full  = (DepthC - count_q) < PwC;
    empty = count_q < PrC;
    push  = wen && !full && !flush;
    pop   = ren && !empty && !flush;
  end

  // Walk write lanes oldest-first, carrying row state across lanes and cycles.
  always_comb begin
    in_row_d  = in_row_q;
    tag_err_d = tag_err_q;
    push_rows = '0;
    lane_tag  = '0;
    tag       = '0;
    for (int i = 0; i < PAR_WRITE; i++) begin
      lane_tag = din[i*W+DATA_WIDTH +: TAG_WIDTH];
      tag      = lane_tag[1:0];
      unique case (tag)
        TAG_SOR: begin
          if (in_row_d) tag_err_d = 1'b1;
          in_row_d = 1'b1;
        end
        TAG_MID: begin
          if (!in_row_d) tag_err_d = 1'b1;
          in_row_d = 1'b1;
        end
        TAG_EOR: begin
          if (!in_row_d) tag_err_d = 1'b1;
          in_row_d  = 1'b0;
          push_rows = push_rows + OneC;
        end
        TAG_SINGLE: begin
          if (in_row_d) tag_err_d = 1'b1;
          in_row_d  = 1'b0;
          push_rows = push_rows + OneC;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pop_rows = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      if (rdata[i*W+DATA_WIDTH]) pop_rows = pop_rows + OneC;
    end
  end

  always_comb begin
    count_d = count_q + (push ? PwC : '0) - (pop ? PrC : '0);
    rows_d  = rows_q + (push ? push_rows : '0) - (pop ? pop_rows : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rows_q       <= '0;
      in_row_q     <= 1'b0;
      tag_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else if (flush) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rows_q       <= '0;
      in_row_q     <= 1'b0;
      tag_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q    <= wptr_q + ADDR_LEN'(PAR_WRITE);
        in_row_q  <= in_row_d;
        tag_err_q <= tag_err_d;
      end
      if (wen && full) overflow_q <= 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + ADDR_LEN'(PAR_READ);
        dout_q <= rdata;
      end
      dout_valid_q <= pop;
      count_q      <= count_d;
      rows_q       <= rows_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign rows_avail = rows_q;
  assign tag_err    = tag_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_tagged_par_fifo.sv
// Scoreboard bench: instance a (PAR_WRITE=2, PAR_READ=1), instance b (PAR_WRITE=1, PAR_READ=4).
module tb_tagged_par_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_wen = 0, a_ren = 0;
  logic [35:0] a_din = '0;
  logic [17:0] a_dout;
  logic        a_dout_valid, a_full, a_empty, a_tag_err, a_overflow;
  logic [3:0]  a_count, a_rows;

  logic        b_flush = 0, b_wen = 0, b_ren = 0;
  logic [17:0] b_din = '0;
  logic [71:0] b_dout;
  logic        b_dout_valid, b_full, b_empty, b_tag_err, b_overflow;
  logic [3:0]  b_count, b_rows;

  tagged_par_fifo #(
    .DATA_WIDTH (16), .TAG_WIDTH (2), .DEPTH (8), .PAR_WRITE (2), .PAR_READ (1)
  ) dut_a (
    .clk (clk), .rst (rst), .flush (a_flush), .wen (a_wen), .din (a_din), .ren (a_ren),
    .dout (a_dout), .dout_valid (a_dout_valid), .full (a_full), .empty (a_empty),
    .count (a_count), .rows_avail (a_rows), .tag_err (a_tag_err), .overflow (a_overflow)
  );

  tagged_par_fifo #(
    .DATA_WIDTH (16), .TAG_WIDTH (2), .DEPTH (8), .PAR_WRITE (1), .PAR_READ (4)
  ) dut_b (
    .clk (clk), .rst (rst), .flush (b_flush), .wen (b_wen), .din (b_din), .ren (b_ren),
    .dout (b_dout), .dout_valid (b_dout_valid), .full (b_full), .empty (b_empty),
    .count (b_count), .rows_avail (b_rows), .tag_err (b_tag_err), .overflow (b_overflow)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for instance a
  logic [17:0] sbq[$];
  int          m_cnt = 0, m_rows = 0;
  logic        m_in_row = 0, m_terr = 0, m_ovf = 0;
  logic [17:0] m_last = '0;

  function automatic logic [17:0] mk(input logic [1:0] t, input logic [15:0] d);
    return {t, d};
  endfunction

  task automatic tag_model(input logic [1:0] t);
    // SOR bit must equal "not currently in a row"
    if (t[1] == m_in_row) m_terr = 1'b1;
    m_in_row = !t[0];
  endtask

  task automatic a_checks();
    check("a_dout", a_dout, m_last);
    check("a_count", a_count, m_cnt);
    check("a_rows", a_rows, m_rows);
    check("a_full", a_full, (m_cnt > 6));
    check("a_empty", a_empty, (m_cnt < 1));
    check("a_tag_err", a_tag_err, m_terr);
    check("a_overflow", a_overflow, m_ovf);
  endtask

  task automatic a_step(input logic w, input logic [17:0] w0, input logic [17:0] w1,
                        input logic r);
    logic push_ok, pop_ok;
    logic [17:0] exp_word;
    exp_word = '0;
    push_ok  = w && ((8 - m_cnt) >= 2);
    pop_ok   = r && (m_cnt >= 1);
    a_wen = w; a_din = {w1, w0}; a_ren = r;
    if (pop_ok) begin
      exp_word = sbq.pop_front();
      m_rows  -= int'(exp_word[16]);
      m_last   = exp_word;
    end
    if (push_ok) begin
      sbq.push_back(w0);
      sbq.push_back(w1);
      tag_model(w0[17:16]);
      tag_model(w1[17:16]);
      m_rows += int'(w0[16]) + int'(w1[16]);
    end
    if (w && !push_ok) m_ovf = 1'b1;
    m_cnt += (push_ok ? 2 : 0) - (pop_ok ? 1 : 0);
    @(posedge clk); #1;
    a_wen = 0; a_ren = 0;
    check("a_dout_valid", a_dout_valid, pop_ok);
    a_checks();
  endtask

  task automatic a_model_clear();
    sbq.delete();
    m_cnt = 0; m_rows = 0; m_in_row = 0; m_terr = 0; m_ovf = 0;
  endtask

  task automatic a_do_flush();
    a_flush = 1;
    @(posedge clk); #1;
    a_flush = 0;
    a_model_clear();
    check("a_flush_dvalid", a_dout_valid, 1'b0);
    a_checks();
  endtask

  logic [17:0] bq[$];
  logic [17:0] rw0, rw1;

  initial begin
    // Test 1: reset values, ordering, row counting
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_dvalid", a_dout_valid, 1'b0);
    a_checks();
    rst = 1;
    @(posedge clk); #1;
    a_step(1, mk(2'b10, -16'sd77), mk(2'b00, 16'd95), 0);
    a_step(1, mk(2'b00, -16'sd1), mk(2'b01, 16'd54), 0);
    for (int i = 0; i < 4; i++) a_step(0, '0, '0, 1);
    a_step(0, '0, '0, 1);  // pop while empty: dout holds, no valid

    // Test 2: full and overflow
    for (int i = 0; i < 5; i++) a_step(1, mk(2'b11, 16'(i*2)), mk(2'b11, 16'(i*2+1)), 0);
    a_step(1, mk(2'b11, 16'hAAAA), mk(2'b11, 16'hBBBB), 1);
    while (m_cnt > 0) a_step(0, '0, '0, 1);
    a_do_flush();

    // Test 3: pointer wrap
    for (int i = 0; i < 3; i++) begin
      rw0 = mk(2'b11, 16'($urandom)); rw1 = mk(2'b11, 16'($urandom));
      a_step(1, rw0, rw1, 0);
    end
    for (int i = 0; i < 5; i++) a_step(0, '0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      rw0 = mk(2'b11, 16'($urandom)); rw1 = mk(2'b11, 16'($urandom));
      a_step(1, rw0, rw1, 0);
    end
    for (int i = 0; i < 7; i++) a_step(0, '0, '0, 1);

    // Test 4: malformed tags still stored, cleared by flush
    a_do_flush();
    a_step(1, mk(2'b00, 16'd5), mk(2'b01, 16'd6), 0);
    check("t4_tag_err", a_tag_err, 1'b1);
    a_step(0, '0, '0, 1);
    a_do_flush();
    check("t4_empty", a_empty, 1'b1);

    // Test 5: PAR_WRITE=1, PAR_READ=4
    for (int i = 0; i < 4; i++) begin
      b_wen = 1; b_din = mk(2'b11, 16'(16'h100 + i * 3));
      bq.push_back(b_din);
      @(posedge clk); #1;
      b_wen = 0;
      check("b_count", b_count, 4'(i + 1));
      check("b_empty", b_empty, (i < 3));
    end
    b_ren = 1;
    @(posedge clk); #1;
    b_ren = 0;
    check("b_dout", b_dout, {bq[3], bq[2], bq[1], bq[0]});
    check("b_dout_valid", b_dout_valid, 1'b1);
    check("b_rows", b_rows, 4'd0);
    check("b_empty_after", b_empty, 1'b1);

    // Test 6: asynchronous reset between edges
    a_step(1, mk(2'b11, 16'h1234), mk(2'b11, 16'h5678), 0);
    a_step(0, '0, '0, 1);
    #2 rst = 0;
    #1;
    check("t6_count", a_count, 4'd0);
    check("t6_dvalid", a_dout_valid, 1'b0);
    check("t6_empty", a_empty, 1'b1);
    check("t6_dout", a_dout, 18'd0);
    #2 rst = 1;
    @(posedge clk); #1;
    a_model_clear();
    m_last = '0;
    a_checks();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
